// File: rtl/wlan_pll_seq_p.sv
// Shared types and constants for the WLAN PLL reset sequencer.
`timescale 1ns/1ps
package wlan_pll_seq_p;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUNNING   = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  // The one state counter must reach the largest terminal count minus one.
  function automatic int lock_cnt_w(input int rst_cycles, input int timeout,
                                    input int stable_cycles);
    int largest;
    largest = rst_cycles;
    if (timeout > largest) largest = timeout;
    if (stable_cycles > largest) largest = stable_cycles;
    return $clog2(largest);
  endfunction

endpackage

// File: rtl/wlan_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
`timescale 1ns/1ps
module wlan_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_bit};
    end
  end

  assign sync_bit = sync_q[STAGES-1];

endmodule

// File: rtl/wlan_pll_reset_seq.sv
// PLL reset / lock sequencer for the 80 MHz WLAN core, clocked from the
// free-running 40 MHz reference so it keeps working while the PLL is down.
//
//   state     | meaning
//   PLL_RESET | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK | PLL released, waiting for lock or timeout
//   STABILIZE | lock seen, waiting for STABLE_CYCLES of continuous lock
//   RUNNING   | core out of reset, ready high
//   FAULT     | retries exhausted, parked until restart
`timescale 1ns/1ps
module wlan_pll_reset_seq
  import wlan_pll_seq_p::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 40000,
  parameter int STABLE_CYCLES  = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int CNT_W   = lock_cnt_w(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic [7:0]         loss_d;
  logic               locked_s;

  wlan_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .async_bit (pll_locked),
    .sync_bit  (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    loss_d    = lock_loss_count;
    retry_inc = retry_q + 1'b1;

    if (restart) begin
      // Restart wins over everything, including a coincident lock loss.
      state_d = PLL_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? FAULT : PLL_RESET;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUNNING;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUNNING: begin
          if (!locked_s) begin
            state_d = PLL_RESET;
            if (lock_loss_count != LOSS_CNT_MAX) loss_d = lock_loss_count + 8'd1;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = PLL_RESET;
      endcase
    end

    if (restart || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= PLL_RESET;
      cnt_q           <= '0;
      retry_q         <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      core_reset      <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      lock_loss_count <= loss_d;
      // Outputs decode the next state so they flip on the same edge as state_q.
      pll_rst         <= (state_d == PLL_RESET) || (state_d == FAULT);
      core_reset      <= (state_d != RUNNING);
      ready           <= (state_d == RUNNING);
      fault           <= (state_d == FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_wlan_pll_reset_seq.sv
// Self-checking bench for wlan_pll_reset_seq: expected state transitions are
// queued per scenario and popped as the DUT changes state.
`timescale 1ns/1ps
module tb_wlan_pll_reset_seq;

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUNNING   = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart    = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] st;
    int         dt;
  } step_t;

  step_t      exp_q[$];
  logic [7:0] exp_loss = 8'd0;

  always #5 clock = ~clock;

  wlan_pll_reset_seq #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .restart        (restart),
    .pll_rst        (pll_rst),
    .core_reset     (core_reset),
    .ready          (ready),
    .fault          (fault),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  // {pll_rst, core_reset, ready, fault} expected in each state
  function automatic logic [3:0] model_out(input logic [2:0] s);
    case (s)
      S_PLL_RESET: return 4'b1100;
      S_WAIT_LOCK: return 4'b0100;
      S_STABILIZE: return 4'b0100;
      S_RUNNING:   return 4'b0010;
      S_FAULT:     return 4'b1101;
      default:     return 4'bxxxx;
    endcase
  endfunction

  function automatic void expect_step(input logic [2:0] st, input int dt);
    exp_q.push_back('{st, dt});
  endfunction

  // Waits for the next state change; dt = posedges since the call, -1 on timeout.
  task automatic next_change(input int budget, output logic [2:0] st, output int dt);
    logic [2:0] cur;
    bit         done;
    cur  = state;
    st   = cur;
    dt   = -1;
    done = 1'b0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(posedge clock);
      #1;
      if (state !== cur) begin
        st   = state;
        dt   = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if ({state, pll_rst, core_reset, ready, fault, lock_loss_count} !== {S_PLL_RESET, 4'b1100, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_values got st=%0d out=%b cnt=%0d, want st=0 out=1100 cnt=0",
               state, {pll_rst, core_reset, ready, fault}, lock_loss_count);
    end
  endtask

  task automatic test_bringup();
    step_t e; logic [2:0] st; int dt;
    expect_step(S_WAIT_LOCK, 4);
    expect_step(S_STABILIZE, 9);
    expect_step(S_RUNNING, 8);
    fork
      begin
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1 pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          next_change(100, st, dt);
          n_tests++;
          if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
            n_fail++;
            $display("FAIL bringup_step got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                     st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
          end
        end
      end
    join
    n_tests++;
    if (lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL bringup_loss got %0d, want 0", lock_loss_count);
    end
  endtask

  task automatic test_stabilize_glitch();
    step_t e; logic [2:0] st; int dt;
    expect_step(S_PLL_RESET, 1);
    expect_step(S_WAIT_LOCK, 4);
    expect_step(S_STABILIZE, 1);
    expect_step(S_WAIT_LOCK, 5);
    expect_step(S_STABILIZE, 1);
    expect_step(S_RUNNING, 8);
    fork
      begin
        restart = 1'b1;
        @(posedge clock);
        #1 restart = 1'b0;
        repeat (7) @(posedge clock);
        #1 pll_locked = 1'b0;
        @(posedge clock);
        #1 pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          next_change(100, st, dt);
          n_tests++;
          if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
            n_fail++;
            $display("FAIL glitch_step got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                     st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
          end
        end
      end
    join
  endtask

  task automatic test_timeout_fault();
    step_t e; logic [2:0] st; int dt;
    expect_step(S_PLL_RESET, 1);
    expect_step(S_WAIT_LOCK, 4);
    expect_step(S_PLL_RESET, 20);
    expect_step(S_WAIT_LOCK, 4);
    expect_step(S_FAULT, 20);
    fork
      begin
        restart    = 1'b1;
        pll_locked = 1'b0;
        @(posedge clock);
        #1 restart = 1'b0;
      end
      begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          next_change(100, st, dt);
          n_tests++;
          if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
            n_fail++;
            $display("FAIL timeout_step got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                     st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
          end
        end
      end
    join
    repeat (30) @(posedge clock);
    #1;
    n_tests++;
    if ({state, pll_rst, fault, lock_loss_count} !== {S_FAULT, 1'b1, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL fault_hold got st=%0d pll_rst=%b fault=%b cnt=%0d, want st=4 pll_rst=1 fault=1 cnt=0",
               state, pll_rst, fault, lock_loss_count);
    end
  endtask

  // Pass 0 restarts out of FAULT, pass 1 restarts out of RUNNING; a single
  // timeout must go back to PLL_RESET both times.
  task automatic test_restart_fault();
    step_t e; logic [2:0] st; int dt;
    for (int pass = 0; pass < 2; pass++) begin
      expect_step(S_PLL_RESET, 1);
      expect_step(S_WAIT_LOCK, 4);
      expect_step(S_PLL_RESET, 20);
      expect_step(S_WAIT_LOCK, 4);
      expect_step(S_STABILIZE, 1);
      expect_step(S_RUNNING, 8);
      fork
        begin
          restart    = 1'b1;
          pll_locked = 1'b0;
          @(posedge clock);
          #1 restart = 1'b0;
          repeat (25) @(posedge clock);
          #1 pll_locked = 1'b1;
        end
        begin
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_change(100, st, dt);
            n_tests++;
            if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
              n_fail++;
              $display("FAIL restart_step pass=%0d got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                       pass, st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
            end
          end
        end
      join
    end
    n_tests++;
    if (lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_loss got %0d, want 0", lock_loss_count);
    end
  endtask

  // Iteration 0 lands restart on the same edge as the lock loss (not counted);
  // the following 260 drops count and must saturate at 255.
  task automatic test_lock_loss();
    step_t e; logic [2:0] st; int dt;
    for (int i = 0; i < 261; i++) begin
      expect_step(S_PLL_RESET, 3);
      expect_step(S_WAIT_LOCK, 4);
      expect_step(S_STABILIZE, 1);
      expect_step(S_RUNNING, 8);
      fork
        begin
          pll_locked = 1'b0;
          @(posedge clock);
          #1 pll_locked = 1'b1;
          if (i == 0) begin
            @(posedge clock);
            #1 restart = 1'b1;
            @(posedge clock);
            #1 restart = 1'b0;
          end
        end
        begin
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_change(100, st, dt);
            n_tests++;
            if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
              n_fail++;
              $display("FAIL loss_step i=%0d got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                       i, st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
            end
          end
        end
      join
      if (i > 0 && exp_loss != 8'd255) exp_loss = exp_loss + 8'd1;
      n_tests++;
      if (lock_loss_count !== exp_loss) begin
        n_fail++;
        $display("FAIL loss_count i=%0d got %0d, want %0d", i, lock_loss_count, exp_loss);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t e; logic [2:0] st; int dt;
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({state, pll_rst, core_reset, ready, fault, lock_loss_count} !== {S_PLL_RESET, 4'b1100, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid got st=%0d out=%b cnt=%0d, want st=0 out=1100 cnt=0",
               state, {pll_rst, core_reset, ready, fault}, lock_loss_count);
    end
    repeat (3) @(posedge clock);
    #1;
    expect_step(S_WAIT_LOCK, 4);
    expect_step(S_STABILIZE, 1);
    expect_step(S_RUNNING, 8);
    fork
      reset_n = 1'b1;
      begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          next_change(100, st, dt);
          n_tests++;
          if (st !== e.st || dt != e.dt || {pll_rst, core_reset, ready, fault} !== model_out(e.st)) begin
            n_fail++;
            $display("FAIL rebringup_step got st=%0d dt=%0d out=%b, want st=%0d dt=%0d out=%b",
                     st, dt, {pll_rst, core_reset, ready, fault}, e.st, e.dt, model_out(e.st));
          end
        end
      end
    join
    n_tests++;
    if (lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rebringup_loss got %0d, want 0", lock_loss_count);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stabilize_glitch();
    test_timeout_fault();
    test_restart_fault();
    test_lock_loss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
